// File: rtl/seq_factorizer.sv
// Sequential divisibility checker: shifts the operand in MSB-first and keeps one
// running remainder per divisor 2..NUM_DIVS+1. The result vector is held until
// the next operation completes.
module seq_factorizer #(
    parameter int unsigned WIDTH    = 7,
    parameter int unsigned NUM_DIVS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    number,
    output logic                busy,
    output logic                done,
    output logic [NUM_DIVS-1:0] factors
);

    // Remainders are strictly below the largest divisor NUM_DIVS+1.
    localparam int unsigned RW  = $clog2(NUM_DIVS + 2);
    localparam int unsigned RW1 = RW + 1;
    localparam int unsigned CW  = $clog2(WIDTH);

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    state_e                     state_q;
    logic [WIDTH-1:0]           shreg_q;
    logic [CW-1:0]              cnt_q;
    logic [NUM_DIVS-1:0][RW-1:0] rem_q;
    logic [NUM_DIVS-1:0][RW-1:0] rem_d;
    logic [NUM_DIVS-1:0]        zero_d;
    logic [RW:0]                t;
    logic [RW:0]                dv;

    // Next remainder per divisor: r' = 2r + bit, minus d once if it overflows.
    always_comb begin
        rem_d  = '0;
        zero_d = '0;
        t      = '0;
        dv     = '0;
        for (int i = 0; i < NUM_DIVS; i++) begin
            dv        = RW1'(i + 2);
            t         = {rem_q[i], shreg_q[WIDTH-1]};
            rem_d[i]  = (t >= dv) ? RW'(t - dv) : t[RW-1:0];
            zero_d[i] = (rem_d[i] == '0);
        end
    end

    // Control FSM with registered busy/done/factors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            factors <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg_q <= number;
                        rem_q   <= '0;
                        cnt_q   <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                    rem_q   <= rem_d;
                    cnt_q   <= cnt_q - CW'(1);
                    // Last bit consumed: publish result and return to idle.
                    if (cnt_q == '0) begin
                        factors <= zero_d;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
